// File: rtl/alu_sort_sched.sv
// alu_sort_sched: sequencer for the top-K sort ALU.
// For each MLU result batch it streams the packed {data[K], index[K]} vector
// into the ALU in 16-word beats. For every batch after the first it also reads
// the running top-K list back from the OutputBuffer. It then commands a
// direct copy (first batch) or a merge (later batches) and drains the result
// beats into the OutputBuffer.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   start, num_batches  one-cycle job start pulse; batch count (sampled on start)
//   mlu_beat_valid/ready  MLU beat handshake (beat sits on the ALU in_mlu bus)
//   obuf_rd_req/beat    one-cycle read request for one stored beat
//   obuf_rd_valid       requested beat present on the ALU in_output bus
//   obuf_wr_en/beat     result beat write to the OutputBuffer
//   obuf_wr_ready       OutputBuffer accepts the write
//   alu_select          01 = MLU beat, 10 = OutputBuffer beat, 00 = none
//   alu_in_count        input beat index (0 when unused)
//   alu_out_count       output beat index (0 when unused)
//   alu_run_case        0000 idle, 0001 copy, 0010 merge
//   busy, done          job in progress; one-cycle job-complete pulse
//   batch_idx           current batch number
module alu_sort_sched #(
  parameter int unsigned K = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_batches,
  input  logic        mlu_beat_valid,
  output logic        mlu_beat_ready,
  output logic        obuf_rd_req,
  output logic [7:0]  obuf_rd_beat,
  input  logic        obuf_rd_valid,
  output logic        obuf_wr_en,
  output logic [7:0]  obuf_wr_beat,
  input  logic        obuf_wr_ready,
  output logic [1:0]  alu_select,
  output logic [31:0] alu_in_count,
  output logic [31:0] alu_out_count,
  output logic [3:0]  alu_run_case,
  output logic        busy,
  output logic        done,
  output logic [15:0] batch_idx
);

  localparam int unsigned BEATS     = (2 * K) / 16 + 1;
  localparam logic [7:0]  LAST_BEAT = 8'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_MLU,
    S_LOAD_OBUF,
    S_COMPUTE,
    S_WRITE,
    S_FIN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_num_batches;
  logic [15:0] r_batch_idx;
  logic [7:0]  r_in_beat;
  logic [7:0]  r_wr_beat;
  logic        r_rd_pend;

  logic        w_start_acc;
  logic        w_mlu_fire;
  logic        w_rd_fire;
  logic        w_wr_fire;
  logic        w_in_last;
  logic        w_wr_last;
  logic        w_first_batch;
  logic        w_more;
  logic [3:0]  w_run_code;

  assign w_in_last     = (r_in_beat == LAST_BEAT);
  assign w_wr_last     = (r_wr_beat == LAST_BEAT);
  assign w_first_batch = (r_batch_idx == '0);
  // 17-bit compare so batch_idx+1 cannot wrap at 16'hFFFF
  assign w_more        = ({1'b0, r_batch_idx} + 17'd1) < {1'b0, r_num_batches};
  assign w_run_code    = w_first_batch ? 4'b0001 : 4'b0010;
  assign batch_idx     = r_batch_idx;

  always_comb begin
    w_next         = r_state;
    w_start_acc    = 1'b0;
    w_mlu_fire     = 1'b0;
    w_rd_fire      = 1'b0;
    w_wr_fire      = 1'b0;
    mlu_beat_ready = 1'b0;
    obuf_rd_req    = 1'b0;
    obuf_rd_beat   = '0;
    obuf_wr_en     = 1'b0;
    obuf_wr_beat   = '0;
    alu_select     = 2'b00;
    alu_in_count   = '0;
    alu_out_count  = '0;
    alu_run_case   = 4'b0000;
    busy           = 1'b0;
    done           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_next      = (num_batches != '0) ? S_LOAD_MLU : S_FIN;
        end
      end
      S_LOAD_MLU: begin
        busy           = 1'b1;
        mlu_beat_ready = 1'b1;
        if (mlu_beat_valid) begin
          w_mlu_fire   = 1'b1;
          alu_select   = 2'b01;
          alu_in_count = 32'(r_in_beat);
          if (w_in_last) w_next = w_first_batch ? S_COMPUTE : S_LOAD_OBUF;
        end
      end
      S_LOAD_OBUF: begin
        busy = 1'b1;
        // valid is only honoured while a request is outstanding
        if (!r_rd_pend) begin
          obuf_rd_req  = 1'b1;
          obuf_rd_beat = r_in_beat;
        end else if (obuf_rd_valid) begin
          w_rd_fire    = 1'b1;
          alu_select   = 2'b10;
          alu_in_count = 32'(r_in_beat);
          if (w_in_last) w_next = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        busy         = 1'b1;
        alu_run_case = w_run_code;
        w_next       = S_WRITE;
      end
      S_WRITE: begin
        busy         = 1'b1;
        alu_run_case = w_run_code;
        obuf_wr_en   = 1'b1;
        obuf_wr_beat = r_wr_beat;
        // lookahead: ALU out register advances only on an accepted write
        alu_out_count = obuf_wr_ready ? (32'(r_wr_beat) + 32'd1) : 32'(r_wr_beat);
        if (obuf_wr_ready) begin
          w_wr_fire = 1'b1;
          if (w_wr_last) w_next = w_more ? S_LOAD_MLU : S_FIN;
        end
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_num_batches <= '0;
      r_batch_idx   <= '0;
      r_in_beat     <= '0;
      r_wr_beat     <= '0;
      r_rd_pend     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_acc) begin
        r_num_batches <= num_batches;
        r_batch_idx   <= '0;
        r_in_beat     <= '0;
        r_wr_beat     <= '0;
        r_rd_pend     <= 1'b0;
      end
      if (obuf_rd_req) r_rd_pend <= 1'b1;
      if (w_rd_fire)   r_rd_pend <= 1'b0;
      if (w_mlu_fire || w_rd_fire) r_in_beat <= w_in_last ? '0 : r_in_beat + 8'd1;
      if (r_state == S_COMPUTE) r_wr_beat <= '0;
      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_beat <= '0;
          if (w_more) r_batch_idx <= r_batch_idx + 16'd1;
        end else begin
          r_wr_beat <= r_wr_beat + 8'd1;
        end
      end
    end
  end

endmodule
